// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode/funct constants, ALU op encoding,
// the decoded-instruction bundle, and the combinational decode function.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [6:0] F7_ADD     = 7'h00;
  localparam logic [6:0] F7_SUB     = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001
  } alu_op_e;

  typedef struct packed {
    logic        is_lui;
    logic        is_i_type;
    alu_op_e     alu_ops;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
  } decoded_t;

  function automatic decoded_t decode(input logic [31:0] instr);
    decoded_t   d;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    d           = '0;
    d.alu_ops   = ALU_ADD;
    d.rs1       = instr[19:15];
    d.rs2       = instr[24:20];
    d.rd        = instr[11:7];
    if (opc == OPC_LUI) begin
      d.is_lui = 1'b1;
      d.imm    = {12'b0, instr[31:12]};
    end else if (opc == OPC_OP_IMM && f3 == F3_ADD) begin
      d.is_i_type = 1'b1;
      d.imm       = {{20{instr[31]}}, instr[31:20]};
    end else if (opc == OPC_OP && f3 == F3_ADD && f7 == F7_ADD) begin
      d.alu_ops = ALU_ADD;
    end else if (opc == OPC_OP && f3 == F3_ADD && f7 == F7_SUB) begin
      d.alu_ops = ALU_SUB;
    end else begin
      d.illegal = 1'b1;
      d.rd      = '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_skid.sv
// Two-entry output/skid buffer for an arbitrary bundle type T.
// in_ready is registered and reflects a free skid slot.
module decode_skid #(
  parameter type T = logic [0:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T     out_q, out_d;
  T     skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic in_ready_q, in_ready_d;
  logic accept, pop;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    accept       = in_valid && in_ready_q && !flush;
    pop          = out_valid_q && out_ready;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || pop) begin
      // in_ready_q is low whenever skid holds data, so no input competes here
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = in_data;
      end
    end else if (accept) begin
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage (LUI/ADDI/ADD/SUB) with a registered 2-entry output buffer.
// Optional illegal-instruction counter enabled by DECODE_ILLEGAL_CNT_EN.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int ILLEGAL_CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_lui,
  output logic        out_is_i_type,
  output logic [3:0]  out_alu_ops,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_illegal
`ifdef DECODE_ILLEGAL_CNT_EN
  ,
  output logic [ILLEGAL_CNT_W-1:0] illegal_cnt
`endif
);

  decoded_t dec;
  decoded_t out_bundle;

  always_comb dec = decode(in_instr);

  decode_skid #(.T(decoded_t)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bundle)
  );

  assign out_is_lui    = out_bundle.is_lui;
  assign out_is_i_type = out_bundle.is_i_type;
  assign out_alu_ops   = out_bundle.alu_ops;
  assign out_imm       = out_bundle.imm;
  assign out_rs1       = out_bundle.rs1;
  assign out_rs2       = out_bundle.rs2;
  assign out_rd        = out_bundle.rd;
  assign out_illegal   = out_bundle.illegal;

`ifdef DECODE_ILLEGAL_CNT_EN
  logic [ILLEGAL_CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic                     accept;

  // Counter is independent of flush; only a genuinely accepted word counts.
  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    accept        = in_valid && in_ready && !flush;
    if (accept && dec.illegal && (illegal_cnt_q != '1))
      illegal_cnt_d = illegal_cnt_q + ILLEGAL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_cnt_q <= '0;
    else        illegal_cnt_q <= illegal_cnt_d;
  end

  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter ILLEGAL_CNT_W, default 8, width of the illegal-instruction counter.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  discards all held instructions.
REQ-005 SHALL have port in_valid  input  1  and in_ready  output  1  as the instruction handshake.
REQ-006 SHALL have port in_instr  input  32  as the RV32I instruction word.
REQ-007 SHALL have port out_valid  output  1  and out_ready  input  1  as the downstream ALU handshake.
REQ-008 SHALL have ports out_is_lui  output  1, out_is_i_type  output  1, out_alu_ops  output  4, out_imm  output  32 as ALU controls.
REQ-009 SHALL have ports out_rs1, out_rs2, out_rd  output  5 each as register indices.
REQ-010 SHALL have port out_illegal  output  1  as unsupported-instruction flag.
REQ-011 SHALL have port illegal_cnt  output  ILLEGAL_CNT_W  as illegal-instruction count (present only with DECODE_ILLEGAL_CNT_EN).

Function
REQ-012 SHALL accept a transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-013 SHALL decode LUI (opcode 0110111): is_lui=1, imm = {12'b0, instr[31:12]} (unshifted; ALU applies <<12).
REQ-014 SHALL decode ADDI (opcode 0010011, funct3 000): is_i_type=1, imm = sign-extended instr[31:20].
REQ-015 SHALL decode ADD/SUB (opcode 0110011, funct3 000, funct7 0x00/0x20): alu_ops 0000/0001, imm=0.
REQ-016 SHALL treat any other encoding as illegal: out_illegal=1, is_lui=0, is_i_type=0, alu_ops=0000, imm=0, rd=0.
REQ-017 SHALL pass rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7] for legal instructions, raw fields regardless of use.
REQ-018 SHALL register decoded results: accepted at edge N, out_valid high after edge N; latency 1 cycle.
REQ-019 SHALL hold a 2-entry storage (output register + skid register); in_ready registered, equal to !skid_full.
REQ-020 SHALL sustain one transfer per cycle when out_ready stays high.
REQ-021 SHALL, on out_ready low with output full, capture the next accepted instruction in skid and deassert in_ready next cycle.
REQ-022 SHALL, when output consumed and skid full, move skid to output same edge and reassert in_ready.
REQ-023 SHALL preserve strict order; no duplicate or dropped instruction except by flush.
REQ-024 SHALL keep all out_* stable while out_valid && !out_ready.
REQ-025 SHALL, on flush, invalidate both entries at the next edge, drop any concurrent input transfer, and set in_ready=1.

Reset
REQ-026 SHALL on rst_n low asynchronously clear out_valid, skid valid, all out_* data to 0, illegal_cnt to 0, and set in_ready=1 on release.
REQ-027 SHALL discard in-flight instructions on reset mid-operation; no transfer in the first post-reset cycle output.

Configuration
REQ-028 SHALL with DECODE_ILLEGAL_CNT_EN defined increment illegal_cnt on each accepted illegal instruction, saturating at all-ones, not cleared by flush.
REQ-029 SHALL without DECODE_ILLEGAL_CNT_EN omit illegal_cnt port and counter logic; out_illegal unaffected.

Structure
REQ-030 SHALL place opcode/funct constants, alu_op enum (ADD=0000, SUB=0001) and decoded-bundle struct in shared package rv32i_pkg.
REQ-031 SHALL implement the 2-entry buffer as sub-module decode_skid, parameterised on the bundle type.

Verification
REQ-032 SHALL cover: 0x123452B7 (LUI x5) -> next cycle out_is_lui=1, out_imm=0x00012345, out_rd=5.
REQ-033 SHALL cover: 0xFFF00093 (ADDI x1,x0,-1) -> out_is_i_type=1, out_imm=0xFFFFFFFF, out_rs1=0, out_rd=1.
REQ-034 SHALL cover: 0x402081B3 (SUB x3,x1,x2) -> out_alu_ops=0001, rs1=1, rs2=2, rd=3; funct7 0x01 variant -> out_illegal=1.
REQ-035 SHALL cover: out_ready=0 for 4 cycles, 3 back-to-back inputs -> 2 accepted, in_ready=0, all 3 delivered in order after release.
REQ-036 SHALL cover: 300 accepted 0x00000000 with ILLEGAL_CNT_W=8 -> out_illegal=1 each, illegal_cnt stops at 255.
REQ-037 SHALL cover: flush with both entries full plus concurrent in_valid -> next cycle out_valid=0, in_ready=1, input not delivered.
